// File: rtl/pwm_sine_pkg.sv
// Shared helpers for the multi-channel sine PWM: index width,
// elaboration-time sine table values and modular index add.
package pwm_sine_pkg;

  function automatic int idx_w(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  function automatic real sin_r(input real x);
    real pi;
    real a;
    real term;
    real sum;
    pi = 3.14159265358979323846;
    a = x;
    while (a > pi) a = a - 2.0 * pi;
    while (a < -pi) a = a + 2.0 * pi;
    term = a;
    sum = a;
    for (int i = 1; i < 14; i++) begin
      term = -term * a * a / real'((2 * i) * (2 * i + 1));
      sum = sum + term;
    end
    return sum;
  endfunction

  // Round half up; the small bias keeps exact .5 ties stable.
  function automatic int sine_val(
    input int k,
    input int r,
    input int steps
  );
    real pi;
    real half;
    real v;
    pi = 3.14159265358979323846;
    half = real'(1 << (r - 1));
    v = half + (half - 1.0) *
        sin_r(2.0 * pi * real'(k) / real'(steps));
    return $rtoi(v + 0.5 + 1.0e-6);
  endfunction

  function automatic int wrap_add(
    input int a,
    input int b,
    input int m
  );
    int s;
    s = a + b;
    return (s >= m) ? s - m : s;
  endfunction

endpackage

// File: rtl/pwm_sine_chan.sv
// One PWM channel: offset index lookup, duty register, output flop.
// PWM_SINE_AMP_EN adds the amp input and scaled duty.
module pwm_sine_chan
  import pwm_sine_pkg::*;
#(
  parameter int R     = 6,
  parameter int STEPS = 36,
  parameter int IW    = idx_w(STEPS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          bnd,
  input  logic [R-1:0]  cnt,
  input  logic [IW-1:0] step_nxt,
  input  logic [IW-1:0] off,
`ifdef PWM_SINE_AMP_EN
  input  logic [R-1:0]  amp,
`endif
  output logic          pwm
);

  localparam int MID  = 1 << (R - 1);
  localparam int MAXV = (1 << R) - 1;

  logic [R-1:0]  tbl [STEPS];
  logic [IW-1:0] off_eff;
  logic [IW-1:0] idx;
  logic [R-1:0]  duty_d;
  logic [R-1:0]  duty_q;

  for (genvar k = 0; k < STEPS; k++) begin : g_tbl
    localparam int V = sine_val(k, R, STEPS);
    assign tbl[k] = R'(V);
  end

  assign off_eff = (int'(off) >= STEPS) ? '0 : off;
  assign idx = IW'(wrap_add(int'(step_nxt), int'(off_eff), STEPS));

`ifdef PWM_SINE_AMP_EN
  always_comb begin : p_amp
    int d;
    int p;
    int v;
    d = int'(tbl[idx]) - MID;
    p = (d * int'(amp)) >>> (R - 1);
    v = MID + p;
    duty_d = '0;
    if (v > MAXV) duty_d = '1;
    else if (v > 0) duty_d = R'(v);
  end
`else
  assign duty_d = tbl[idx];
`endif

  // Duty only changes on a period boundary so pulses never split.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      duty_q <= '0;
      pwm    <= 1'b0;
    end else begin
      if (bnd) duty_q <= duty_d;
      pwm <= en & (cnt < duty_q);
    end
  end

endmodule

// File: rtl/pwm_sine_multich.sv
// Multi-channel sine PWM: shared counter and step sequencer.
// Optional amplitude scaling via macro PWM_SINE_AMP_EN.
module pwm_sine_multich
  import pwm_sine_pkg::*;
#(
  parameter int R     = 6,
  parameter int STEPS = 36,
  parameter int CH    = 3,
  parameter int DIV_W = 5,
  localparam int IW   = idx_w(STEPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  input  logic [CH*IW-1:0] phase_off,
`ifdef PWM_SINE_AMP_EN
  input  logic [R-1:0]     amp,
`endif
  output logic [CH-1:0]    pwm_out,
  output logic [IW-1:0]    step_idx,
  output logic             cycle_done
);

  logic [R-1:0]     cnt;
  logic [DIV_W-1:0] n;
  logic [DIV_W:0]   n_inc;
  logic [DIV_W:0]   div_eff;
  logic             bnd;
  logic             adv;
  logic             wrap;
  logic [IW-1:0]    step_nxt;

  assign bnd     = en & (cnt == '1);
  assign div_eff = (div == '0) ? (DIV_W+1)'(1) : {1'b0, div};
  assign n_inc   = {1'b0, n} + (DIV_W+1)'(1);
  // >= rather than == so a lowered div advances immediately.
  assign adv     = bnd & (n_inc >= div_eff);
  assign wrap    = adv & (step_idx == IW'(STEPS - 1));
  assign step_nxt = adv
    ? IW'(wrap_add(int'(step_idx), 1, STEPS))
    : step_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      n          <= '0;
      step_idx   <= '0;
      cycle_done <= 1'b0;
    end else begin
      cycle_done <= wrap;
      if (en) cnt <= cnt + R'(1);
      if (bnd) begin
        n        <= adv ? '0 : n + DIV_W'(1);
        step_idx <= step_nxt;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    pwm_sine_chan #(
      .R     (R),
      .STEPS (STEPS),
      .IW    (IW)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .bnd      (bnd),
      .cnt      (cnt),
      .step_nxt (step_nxt),
      .off      (phase_off[c*IW +: IW]),
`ifdef PWM_SINE_AMP_EN
      .amp      (amp),
`endif
      .pwm      (pwm_out[c])
    );
  end

endmodule

// File: tb/tb_pwm_sine_multich.sv
// Bench for pwm_sine_multich: directed phases plus random
// en/div/offset changes against a period-level reference model.
`timescale 1ns/1ps
module tb_pwm_sine_multich;

  localparam int R     = 6;
  localparam int STEPS = 36;
  localparam int CH    = 3;
  localparam int DIV_W = 5;
  localparam int IW    = 6;
  localparam int PER   = 1 << R;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] div;
  logic [CH*IW-1:0] phase_off;
  logic [CH-1:0]    pwm_out;
  logic [IW-1:0]    step_idx;
  logic             cycle_done;
`ifdef PWM_SINE_AMP_EN
  logic [R-1:0]     amp;
`endif

  always #5 clk = ~clk;

  pwm_sine_multich #(
    .R(R), .STEPS(STEPS), .CH(CH), .DIV_W(DIV_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .div        (div),
    .phase_off  (phase_off),
`ifdef PWM_SINE_AMP_EN
    .amp        (amp),
`endif
    .pwm_out    (pwm_out),
    .step_idx   (step_idx),
    .cycle_done (cycle_done)
  );

  int tests = 0;
  int fails = 0;

  int tbl_m [STEPS];
  int m_pos, m_n, m_step, m_bnds;
  int m_duty [CH];
  int e_cnt, last_cd;
  bit chk_cd, chk_hc;
  int hc [CH];

  function automatic int sine_ref(input int k);
    real half;
    real v;
    half = 2.0 ** (R - 1);
    v = half + (half - 1.0) *
        $sin(2.0 * 3.14159265358979323846 * k / STEPS);
    return int'($floor(v + 0.5 + 1.0e-6));
  endfunction

  function automatic int model_duty(input int v);
`ifdef PWM_SINE_AMP_EN
    int mid;
    int r;
    mid = PER / 2;
    r = mid + (((v - mid) * int'(amp)) >>> (R - 1));
    if (r < 0) r = 0;
    if (r > PER - 1) r = PER - 1;
    return r;
`else
    return v;
`endif
  endfunction

  function automatic int off_of(input int c);
    int o;
    o = int'(phase_off[c*IW +: IW]);
    return (o >= STEPS) ? 0 : o;
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] expv
  );
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_n    = 0;
    m_step = 0;
    m_bnds = 0;
    e_cnt  = 0;
    last_cd = 0;
    for (int c = 0; c < CH; c++) m_duty[c] = 0;
  endtask

  task automatic tick();
    logic [CH-1:0] ep;
    bit ecd;
    bit en_b;
    int pos_b, step_b, bnds_b, de;
    @(posedge clk);
    en_b = en;
    pos_b = m_pos;
    step_b = m_step;
    bnds_b = m_bnds;
    ecd = 1'b0;
    for (int c = 0; c < CH; c++)
      ep[c] = en && (m_pos < m_duty[c]);
    if (en) begin
      e_cnt++;
      if (m_pos == PER - 1) begin
        de = (div == '0) ? 1 : int'(div);
        m_bnds++;
        if (m_n + 1 >= de) begin
          m_n = 0;
          m_step = (m_step + 1) % STEPS;
          ecd = (m_step == 0);
        end else begin
          m_n++;
        end
        for (int c = 0; c < CH; c++)
          m_duty[c] = model_duty(
            tbl_m[(m_step + off_of(c)) % STEPS]);
      end
      m_pos = (m_pos + 1) % PER;
    end
    @(negedge clk);
    chk("pwm_out", 32'(pwm_out), 32'(ep));
    chk("step_idx", 32'(step_idx), m_step);
    chk("cycle_done", 32'(cycle_done), 32'(ecd));
    if (chk_cd && cycle_done === 1'b1) begin
      if (last_cd > 0)
        chk("cd_spacing", e_cnt - last_cd, STEPS * PER);
      last_cd = e_cnt;
    end
    if (chk_hc && en_b) begin
      if (pos_b == 0)
        for (int c = 0; c < CH; c++) hc[c] = 0;
      for (int c = 0; c < CH; c++)
        hc[c] += int'(pwm_out[c]);
      if (pos_b == PER - 1 && bnds_b > 0) begin
        if (step_b == 0) begin
          chk("hc_s0_ch0", hc[0], 32);
          chk("hc_s0_ch1", hc[1], 59);
          chk("hc_s0_ch2", hc[2], 5);
        end
        if (step_b == 9) begin
          chk("hc_s9_ch0", hc[0], 63);
          chk("hc_s9_ch1", hc[1], 17);
          chk("hc_s9_ch2", hc[2], 17);
        end
      end
    end
  endtask

  initial begin
    int guard;
    int hi;
    for (int k = 0; k < STEPS; k++) tbl_m[k] = sine_ref(k);
    chk_cd = 1'b0;
    chk_hc = 1'b0;
    rst = 1'b0;
    en = 1'b0;
    div = 5'd1;
    phase_off = '0;
`ifdef PWM_SINE_AMP_EN
    amp = 6'd32;
`endif
    model_reset();

    #1 rst = 1'b1;
    #1;
    chk("rst0_pwm", 32'(pwm_out), 0);
    chk("rst0_step", 32'(step_idx), 0);
    chk("rst0_cd", 32'(cycle_done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    en = 1'b1;
    repeat (300) tick();

    // asynchronous reset while channel 0 is high
    guard = 0;
    while (pwm_out[0] !== 1'b1 && guard < 200) begin
      tick();
      guard++;
    end
    chk("pre_reset_high", 32'(pwm_out[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_step", 32'(step_idx), 0);
    chk("rst_cd", 32'(cycle_done), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    phase_off = {6'd24, 6'd12, 6'd0};
    chk_hc = 1'b1;
    chk_cd = 1'b1;
    hi = 0;
    repeat (PER) begin
      tick();
      hi += $countones(pwm_out);
    end
    chk("first_period_low", hi, 0);
    repeat (2 * STEPS * PER + 100 - PER) tick();
    chk_hc = 1'b0;
    chk_cd = 1'b0;

    div = 5'd0;
    repeat (600) tick();

    // en gap mid-period
    guard = 0;
    while (m_pos != 20 && guard < 2 * PER) begin
      tick();
      guard++;
    end
    en = 1'b0;
    hi = 0;
    repeat (100) begin
      tick();
      hi += $countones(pwm_out);
    end
    chk("gap_low", hi, 0);
    en = 1'b1;
    repeat (300) tick();

    // div 5 lowered to 2 mid-count; ch1 offset out of range
    div = 5'd5;
    phase_off = {6'd0, 6'd40, 6'd0};
    guard = 0;
    while (!(m_n == 3 && m_pos == 10) && guard < 8 * PER) begin
      tick();
      guard++;
    end
    div = 5'd2;
    repeat (8 * PER) tick();

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 63) == 0) en = ~en;
      if ($urandom_range(0, 199) == 0)
        div = DIV_W'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0)
        phase_off = (CH*IW)'($urandom);
      tick();
    end
    en = 1'b1;
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
